// File: rtl/vdp_super_res_writer_if.sv
// Bus bundle for the super-res VRAM writer.
//   Video timing : vdp_super, cx, last_line, super_res_visible (to writer)
//   CPU port     : cpu_wr, cpu_port, cpu_data (to writer)
//   VRAM write   : vram_wr, vram_addr, vram_wdata, vram_be (from writer)
//   Status       : fifo_full, busy, overflow (from writer)
// master = the surrounding VDP/CPU side, slave = the writer itself.
interface vdp_super_res_writer_if;
   logic        vdp_super;
   logic [9:0]  cx;
   logic        last_line;
   logic        super_res_visible;
   logic        cpu_wr;
   logic [1:0]  cpu_port;
   logic [7:0]  cpu_data;
   logic        vram_wr;
   logic [17:0] vram_addr;
   logic [31:0] vram_wdata;
   logic [3:0]  vram_be;
   logic        fifo_full;
   logic        busy;
   logic        overflow;

   modport master (
      output vdp_super, cx, last_line, super_res_visible, cpu_wr, cpu_port, cpu_data,
      input  vram_wr, vram_addr, vram_wdata, vram_be, fifo_full, busy, overflow
   );

   modport slave (
      input  vdp_super, cx, last_line, super_res_visible, cpu_wr, cpu_port, cpu_data,
      output vram_wr, vram_addr, vram_wdata, vram_be, fifo_full, busy, overflow
   );
endinterface

// File: rtl/vdp_super_res_writer.sv
// Super-res VRAM writer: CPU bytes are queued (4 deep) with the byte address captured at
// push time, then issued as single-byte VRAM writes in cycles the display reader leaves free.
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high
//   bus_io : writer side of vdp_super_res_writer_if (timing, CPU port, VRAM write, status)
module vdp_super_res_writer (
   input  logic                         clk,
   input  logic                         reset,
   vdp_super_res_writer_if.slave        bus_io
);
   typedef enum logic [1:0] {StIdle, StWait, StWrite} state_e;
   typedef struct packed {
      logic [19:0] addr;
      logic [7:0]  data;
   } entry_t;

   state_e      state_q, state_d;
   entry_t      fifo_q [4];
   logic [1:0]  rd_ptr_q, wr_ptr_q;
   logic [2:0]  count_q, count_d;
   logic [19:0] ptr_q, ptr_d;
   logic        ovf_q, ovf_d;
   logic [17:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        fetch_block, slot, full, pop, data_wr, push;
   entry_t      head;

   always_comb begin
      // Reader fetches the next line's start at the end of the last line.
      fetch_block = bus_io.last_line && (bus_io.cx >= 10'd720) && (bus_io.cx <= 10'd725);
      // Inside the visible area the reader leaves one cycle in four free.
      slot        = !fetch_block && (!bus_io.super_res_visible || (bus_io.cx[1:0] == 2'd2));
      full        = (count_q == 3'd4);
      pop         = bus_io.vdp_super && (count_q != 3'd0) && slot;
      data_wr     = bus_io.vdp_super && bus_io.cpu_wr && (bus_io.cpu_port == 2'd0);
      push        = data_wr && (!full || pop);
      head        = fifo_q[rd_ptr_q];
      count_d     = bus_io.vdp_super ? (count_q + {2'b00, push} - {2'b00, pop}) : 3'd0;
   end

   // Pointer, overflow and registered VRAM outputs.
   always_comb begin
      ptr_d   = ptr_q;
      ovf_d   = ovf_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      if (!bus_io.vdp_super) begin
         ptr_d   = '0;
         ovf_d   = 1'b0;
         addr_d  = '0;
         be_d    = '0;
         wdata_d = '0;
      end else begin
         if (bus_io.cpu_wr) begin
            unique case (bus_io.cpu_port)
               2'd0: begin
                  if (push) ptr_d = ptr_q + 20'd1;
                  else      ovf_d = 1'b1;
               end
               2'd1: begin
                  ptr_d[7:0] = bus_io.cpu_data;
                  ovf_d      = 1'b0;
               end
               2'd2: ptr_d[15:8]  = bus_io.cpu_data;
               2'd3: ptr_d[19:16] = bus_io.cpu_data[3:0];
               default: ;
            endcase
         end
         if (pop) begin
            addr_d  = head.addr[19:2];
            be_d    = 4'b0001 << head.addr[1:0];
            wdata_d = {4{head.data}};
         end
      end
   end

   // Issue FSM next state.
   always_comb begin
      state_d = StIdle;
      if (bus_io.vdp_super) begin
         unique case (state_q)
            StIdle: state_d = (count_d != 3'd0) ? StWait : StIdle;
            StWait, StWrite: begin
               if (pop)                   state_d = StWrite;
               else if (count_d != 3'd0) state_d = StWait;
               else                       state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ptr_q    <= '0;
         ovf_q    <= 1'b0;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ptr_q   <= ptr_d;
         ovf_q   <= ovf_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         if (!bus_io.vdp_super) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            // When full with a pop, wr_ptr == rd_ptr: head is read before it is overwritten.
            if (push) begin
               fifo_q[wr_ptr_q] <= '{addr: ptr_q, data: bus_io.cpu_data};
               wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
         end
      end
   end

   assign bus_io.vram_wr    = (state_q == StWrite);
   assign bus_io.vram_addr  = addr_q;
   assign bus_io.vram_be    = be_q;
   assign bus_io.vram_wdata = wdata_q;
   assign bus_io.fifo_full  = full;
   assign bus_io.busy       = (count_q != 3'd0) || (state_q == StWrite);
   assign bus_io.overflow   = ovf_q;
endmodule

// File: tb/tb_vdp_super_res_writer.sv
// Self-checking bench for vdp_super_res_writer: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_vdp_super_res_writer;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   vdp_super_res_writer_if bus ();

   vdp_super_res_writer dut (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] a;
      logic [7:0]  d;
   } ent_t;

   // Reference model state
   ent_t        mq[$];
   int unsigned m_ptr;
   bit          m_ovf;
   bit          m_wr;
   logic [17:0] m_addr;
   logic [3:0]  m_be;
   logic [31:0] m_wdata;

   task automatic model_clear();
      mq.delete();
      m_ptr   = 0;
      m_ovf   = 0;
      m_wr    = 0;
      m_addr  = '0;
      m_be    = '0;
      m_wdata = '0;
   endtask

   // Advance one clock: update the model from the inputs seen before the edge, then step.
   task automatic tick();
      ent_t e;
      bit   slot;
      bit   pop;
      if (!bus.vdp_super) begin
         model_clear();
      end else begin
         slot = !(bus.last_line && bus.cx >= 720 && bus.cx <= 725) &&
                (!bus.super_res_visible || (bus.cx % 4) == 2);
         pop  = slot && (mq.size() > 0);
         m_wr = pop;
         if (pop) begin
            e       = mq.pop_front();
            m_addr  = 18'(e.a >> 2);
            m_be    = 4'b0001 << e.a[1:0];
            m_wdata = {4{e.d}};
         end
         if (bus.cpu_wr) begin
            case (bus.cpu_port)
               2'd0: begin
                  if (mq.size() < 4) begin
                     e.a = 20'(m_ptr);
                     e.d = bus.cpu_data;
                     mq.push_back(e);
                     m_ptr = (m_ptr + 1) % (1 << 20);
                  end else begin
                     m_ovf = 1;
                  end
               end
               2'd1: begin
                  m_ptr = (m_ptr & 32'hFFF00) | 32'(bus.cpu_data);
                  m_ovf = 0;
               end
               2'd2: m_ptr = (m_ptr & 32'hF00FF) | (32'(bus.cpu_data) << 8);
               default: m_ptr = (m_ptr & 32'h0FFFF) | (32'(bus.cpu_data % 16) << 16);
            endcase
         end
      end
      @(posedge clk);
      #1;
      bus.cpu_wr = 1'b0;
   endtask

   task automatic cpu(input logic [1:0] p, input logic [7:0] d);
      bus.cpu_wr   = 1'b1;
      bus.cpu_port = p;
      bus.cpu_data = d;
      tick();
   endtask

   task automatic test_reset();
      model_clear();
      reset = 1'b1;
      #12;
      n_checks++;
      if ({bus.vram_wr, bus.vram_addr, bus.vram_be, bus.vram_wdata} !== 55'd0)
         $display("FAIL reset_outputs: got %h want 0",
                  {bus.vram_wr, bus.vram_addr, bus.vram_be, bus.vram_wdata});
      else n_pass++;
      n_checks++;
      if ({bus.fifo_full, bus.busy, bus.overflow} !== 3'b000)
         $display("FAIL reset_status: got %b want 000", {bus.fifo_full, bus.busy, bus.overflow});
      else n_pass++;
      #1;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic_write();
      bus.super_res_visible = 1'b0;
      bus.last_line = 1'b0;
      bus.cx = 10'd0;
      cpu(2'd1, 8'h05);
      cpu(2'd2, 8'h00);
      cpu(2'd3, 8'h00);
      cpu(2'd0, 8'hAA);
      n_checks++;
      if (bus.vram_wr !== 1'b0) $display("FAIL basic_no_early: got %b want 0", bus.vram_wr);
      else n_pass++;
      tick();
      n_checks++;
      if ({bus.vram_wr, bus.vram_addr, bus.vram_be, bus.vram_wdata} !==
          {1'b1, 18'h00001, 4'b0010, 32'hAAAAAAAA})
         $display("FAIL basic_write: got wr=%b addr=%h be=%b wd=%h want 1 00001 0010 aaaaaaaa",
                  bus.vram_wr, bus.vram_addr, bus.vram_be, bus.vram_wdata);
      else n_pass++;
      cpu(2'd0, 8'h3C);
      tick();
      n_checks++;
      if ({bus.vram_addr, bus.vram_be} !== {18'h00001, 4'b0100})
         $display("FAIL basic_ptr_inc: got addr=%h be=%b want 00001 0100",
                  bus.vram_addr, bus.vram_be);
      else n_pass++;
      tick();
      n_checks++;
      if ({bus.vram_wr, bus.vram_wdata, bus.busy} !== {1'b0, 32'h3C3C3C3C, 1'b0})
         $display("FAIL basic_hold: got wr=%b wd=%h busy=%b want 0 3c3c3c3c 0",
                  bus.vram_wr, bus.vram_wdata, bus.busy);
      else n_pass++;
   endtask

   task automatic test_visible_slots();
      int got[$];
      bus.super_res_visible = 1'b1;
      bus.cx = 10'd100;
      cpu(2'd0, 8'h01);
      cpu(2'd0, 8'h02);
      cpu(2'd0, 8'h03);
      for (int c = 100; c < 116; c++) begin
         bus.cx = 10'(c);
         tick();
         if (bus.vram_wr) got.push_back(c);
      end
      n_checks++;
      if (got.size() != 3 || got[0] != 102 || got[1] != 106 || got[2] != 110)
         $display("FAIL visible_slots: got %p want '{102,106,110}", got);
      else n_pass++;
   endtask

   task automatic test_overflow();
      int writes;
      bus.super_res_visible = 1'b1;
      bus.cx = 10'd100;
      for (int i = 0; i < 4; i++) cpu(2'd0, 8'(8'h40 + i));
      n_checks++;
      if ({bus.fifo_full, bus.overflow} !== 2'b10)
         $display("FAIL ovf_full4: got full,ovf=%b want 10", {bus.fifo_full, bus.overflow});
      else n_pass++;
      cpu(2'd0, 8'h99);
      n_checks++;
      if ({bus.fifo_full, bus.overflow} !== 2'b11)
         $display("FAIL ovf_drop: got full,ovf=%b want 11", {bus.fifo_full, bus.overflow});
      else n_pass++;
      cpu(2'd1, 8'h00);
      n_checks++;
      if (bus.overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", bus.overflow);
      else n_pass++;
      bus.super_res_visible = 1'b0;
      writes = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.vram_wr) writes++;
      end
      n_checks++;
      if (writes != 4 || bus.busy !== 1'b0)
         $display("FAIL ovf_drain: got writes=%0d busy=%b want 4 0", writes, bus.busy);
      else n_pass++;
   endtask

   task automatic test_wrap();
      bus.super_res_visible = 1'b0;
      cpu(2'd1, 8'hFF);
      cpu(2'd2, 8'hFF);
      cpu(2'd3, 8'h0F);
      cpu(2'd0, 8'h11);
      cpu(2'd0, 8'h22);
      n_checks++;
      if ({bus.vram_wr, bus.vram_addr, bus.vram_be} !== {1'b1, 18'h3FFFF, 4'b1000})
         $display("FAIL wrap_top: got wr=%b addr=%h be=%b want 1 3ffff 1000",
                  bus.vram_wr, bus.vram_addr, bus.vram_be);
      else n_pass++;
      tick();
      n_checks++;
      if ({bus.vram_wr, bus.vram_addr, bus.vram_be} !== {1'b1, 18'h00000, 4'b0001})
         $display("FAIL wrap_zero: got wr=%b addr=%h be=%b want 1 00000 0001",
                  bus.vram_wr, bus.vram_addr, bus.vram_be);
      else n_pass++;
      tick();
   endtask

   task automatic test_last_line();
      logic [7:0] seen;
      bus.super_res_visible = 1'b0;
      bus.last_line = 1'b1;
      bus.cx = 10'd720;
      cpu(2'd0, 8'h51);
      cpu(2'd0, 8'h52);
      cpu(2'd0, 8'h53);
      for (int c = 719; c <= 726; c++) begin
         bus.cx = 10'(c);
         tick();
         seen[c - 719] = bus.vram_wr;
      end
      n_checks++;
      if (seen !== 8'b1000_0001)
         $display("FAIL last_line_gap: got %b want 10000001 (bit0=cx719)", seen);
      else n_pass++;
      bus.last_line = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid_write();
      int writes;
      bus.super_res_visible = 1'b1;
      bus.cx = 10'd100;
      for (int i = 0; i < 4; i++) cpu(2'd0, 8'(8'h70 + i));
      bus.cx = 10'd102;
      tick();
      n_checks++;
      if ({bus.vram_wr, bus.fifo_full} !== 2'b10)
         $display("FAIL rst_mid_setup: got wr,full=%b want 10", {bus.vram_wr, bus.fifo_full});
      else n_pass++;
      #2;
      reset = 1'b1;
      model_clear();
      #1;
      n_checks++;
      if ({bus.vram_wr, bus.vram_addr, bus.vram_be, bus.vram_wdata, bus.busy,
           bus.fifo_full, bus.overflow} !== 58'd0)
         $display("FAIL rst_mid_clear: got wr=%b addr=%h be=%b wd=%h busy=%b full=%b want 0",
                  bus.vram_wr, bus.vram_addr, bus.vram_be, bus.vram_wdata, bus.busy,
                  bus.fifo_full);
      else n_pass++;
      reset = 1'b0;
      writes = 0;
      for (int c = 100; c < 112; c++) begin
         bus.cx = 10'(c);
         tick();
         if (bus.vram_wr) writes++;
      end
      n_checks++;
      if (writes != 0) $display("FAIL rst_mid_nowrite: got %0d writes want 0", writes);
      else n_pass++;
   endtask

   task automatic test_super_off();
      bus.super_res_visible = 1'b1;
      bus.cx = 10'd100;
      cpu(2'd1, 8'h37);
      cpu(2'd0, 8'hE1);
      cpu(2'd0, 8'hE2);
      bus.vdp_super = 1'b0;
      cpu(2'd0, 8'hE3);
      n_checks++;
      if ({bus.busy, bus.vram_wr, bus.vram_wdata} !== 34'd0)
         $display("FAIL super_off_flush: got busy=%b wr=%b wd=%h want 0",
                  bus.busy, bus.vram_wr, bus.vram_wdata);
      else n_pass++;
      bus.vdp_super = 1'b1;
      bus.super_res_visible = 1'b0;
      cpu(2'd0, 8'h5A);
      tick();
      n_checks++;
      if ({bus.vram_wr, bus.vram_addr, bus.vram_be} !== {1'b1, 18'h0, 4'b0001})
         $display("FAIL super_off_ptr0: got wr=%b addr=%h be=%b want 1 00000 0001",
                  bus.vram_wr, bus.vram_addr, bus.vram_be);
      else n_pass++;
      tick();
   endtask

   task automatic test_random();
      logic [57:0] got;
      logic [57:0] exp;
      for (int i = 0; i < 600; i++) begin
         bus.vdp_super         = ($urandom_range(0, 39) != 0);
         bus.last_line         = ($urandom_range(0, 3) == 0);
         bus.super_res_visible = $urandom_range(0, 1);
         bus.cx = ($urandom_range(0, 2) == 0) ? 10'(716 + $urandom_range(0, 12))
                                              : 10'($urandom_range(0, 1023));
         bus.cpu_wr   = ($urandom_range(0, 1) == 1);
         bus.cpu_port = ($urandom_range(0, 2) != 0) ? 2'd0 : 2'($urandom_range(0, 3));
         bus.cpu_data = 8'($urandom);
         tick();
         got = {bus.vram_wr, bus.vram_addr, bus.vram_be, bus.vram_wdata,
                bus.fifo_full, bus.busy, bus.overflow};
         exp = {m_wr, m_addr, m_be, m_wdata, (mq.size() == 4), (mq.size() > 0 || m_wr), m_ovf};
         n_checks++;
         if (got !== exp) $display("FAIL random_cycle%0d: got %h want %h", i, got, exp);
         else n_pass++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset = 1'b1;
      bus.vdp_super = 1'b1;
      bus.cx = '0;
      bus.last_line = 1'b0;
      bus.super_res_visible = 1'b0;
      bus.cpu_wr = 1'b0;
      bus.cpu_port = '0;
      bus.cpu_data = '0;
      test_reset();
      test_basic_write();
      test_visible_slots();
      test_overflow();
      test_wrap();
      test_last_line();
      test_reset_mid_write();
      test_super_off();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
